// File: rtl/wbm_rr_arbiter.sv
// Round-robin WISHBONE arbiter: one target shared by NUM_MASTERS initiators,
// grant held for a whole CYC, watchdog forces ERR on unanswered strobes.
module wbm_rr_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_sel_i,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [NUM_MASTERS-1:0]                m_rty_o,
  output logic [DATA_WIDTH-1:0]                 m_dat_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic                                  s_we_o,
  output logic [ADDRESS_WIDTH-1:0]              s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  input  logic                                  s_ack_i,
  input  logic                                  s_err_i,
  input  logic                                  s_rty_i,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  output logic [NUM_MASTERS-1:0]                grant_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int WW = (CW < 8) ? 8 : ((CW > 16) ? 16 : CW);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d, pick;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   owned, own_cyc, own_stb;
  logic                   term, wd_fire;

  // last_q doubles as the owner index while OWNED
  assign owned   = (state_q == OWNED);
  assign own_cyc = m_cyc_i[last_q];
  assign own_stb = m_stb_i[last_q];
  assign term    = s_ack_i | s_err_i | s_rty_i;
  assign wd_fire = (TIMEOUT > 0) && owned && own_stb
                   && !term && (wd_q == WD_MAX);

  assign s_cyc_o = owned & own_cyc;
  assign s_stb_o = owned & own_stb & ~wd_fire;
  assign s_we_o  = m_we_i[last_q];
  assign s_adr_o = m_adr_i[last_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign s_dat_o = m_dat_i[last_q*DATA_WIDTH +: DATA_WIDTH];
  assign s_sel_o = m_sel_i[last_q*SW +: SW];
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (owned) begin
      m_ack_o[last_q] = s_ack_i;
      m_err_o[last_q] = s_err_i | wd_fire;
      m_rty_o[last_q] = s_rty_i;
    end
  end

  // Descending scan so the nearest requester after last_q wins
  always_comb begin
    pick = last_q;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      if (m_cyc_i[IW'((int'(last_q) + i) % NUM_MASTERS)])
        pick = IW'((int'(last_q) + i) % NUM_MASTERS);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d       = OWNED;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (own_stb && !term && !wd_fire
                     && wd_q != WD_MAX) begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// Scoreboard bench for wbm_rr_arbiter: random request episodes, a target
// model with wait states/errors/timeouts, and a round-robin order model.
module tb_wbm_rr_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [63:0] m_adr_i;
  logic [127:0] m_dat_i;
  logic [15:0] m_sel_i;
  logic [3:0]  m_ack_o, m_err_o, m_rty_o;
  logic [31:0] m_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [15:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [31:0] s_dat_i;
  logic [3:0]  grant_o;

  always #5 clk = ~clk;

  wbm_rr_arbiter #(
    .NUM_MASTERS(4), .ADDRESS_WIDTH(16),
    .DATA_WIDTH(32), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  // Per-master, per-beat transaction plan
  int          p_nb[4];
  int          p_wait[4][3];
  logic [2:0]  p_resp[4][3];
  logic        p_to[4][3];
  logic [15:0] p_adr[4][3];
  logic [31:0] p_dat[4][3];
  logic [3:0]  p_sel[4][3];
  logic        p_we[4][3];

  typedef struct {
    int          k;
    logic [2:0]  resp;
    logic        to;
    int          wt;
    logic [15:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } exp_t;

  int   gq[$];
  exp_t tq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ptr;
  int   go_ep = 0;
  logic [3:0] req = '0;
  logic abort = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  assign s_dat_i = {s_adr_o, ~s_adr_o};

  // Masters: each runs its planned beats when its bit of req is set
  for (genvar g = 0; g < 4; g++) begin : mst
    logic        cyc, stb, we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          fin;
    assign m_cyc_i[g] = cyc;
    assign m_stb_i[g] = stb;
    assign m_we_i[g]  = we;
    assign m_adr_i[g*16 +: 16] = adr;
    assign m_dat_i[g*32 +: 32] = dat;
    assign m_sel_i[g*4 +: 4]   = sel;
    initial begin
      int   seen;
      logic hit;
      cyc = 0; stb = 0; we = 0;
      adr = '0; dat = '0; sel = '0;
      fin = 0; seen = 0;
      forever begin
        wait (go_ep != seen);
        seen = go_ep;
        if (req[g]) begin
          for (int b = 0; b < p_nb[g]; b++) begin
            if (abort) break;
            cyc = 1; stb = 1;
            we = p_we[g][b]; adr = p_adr[g][b];
            dat = p_dat[g][b]; sel = p_sel[g][b];
            hit = 0;
            while (!hit && !abort) begin
              @(negedge clk); #2;
              hit = m_ack_o[g] | m_err_o[g] | m_rty_o[g];
            end
            if (hit) begin
              @(posedge clk); #1;
            end
          end
          cyc = 0; stb = 0;
        end
        fin = seen;
      end
    end
  end

  // Target: answers after the planned number of wait states
  initial begin
    int w, k, b;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    w = 0;
    forever begin
      @(negedge clk);
      if (s_cyc_o && s_stb_o) begin
        k = int'(s_adr_o[3:2]);
        b = int'(s_adr_o[1:0]);
        if (b < 3 && !p_to[k][b] && w == p_wait[k][b]) begin
          {s_rty_i, s_err_i, s_ack_i} = p_resp[k][b];
          w = 0;
        end else w++;
      end else w = 0;
      @(posedge clk); #1;
      {s_rty_i, s_err_i, s_ack_i} = 3'b000;
    end
  end

  // Monitor: pops grant and termination expectations as they appear
  initial begin
    logic [3:0] prev_g, oh;
    int   idle, sc, gk;
    exp_t e;
    prev_g = 0; idle = 0; sc = 0;
    forever begin
      @(negedge clk); #2;
      if (rst_i) begin
        prev_g = 0; idle = 0; sc = 0;
      end else begin
        if (grant_o == 0 && m_cyc_i != 0) idle++;
        if (grant_o != 0 && prev_g == 0) begin
          if (gq.size() == 0) chk("unexpected_grant", grant_o, 0);
          else begin
            gk = gq.pop_front();
            oh = 4'b1 << gk;
            chk("grant", grant_o, oh);
            chk("idle_gap", idle, 1);
            chk("s_cyc_on_grant", s_cyc_o, 1);
          end
          idle = 0; sc = 0;
        end else if (grant_o != 0 && grant_o != prev_g)
          chk("grant_switch", grant_o, prev_g);
        if (grant_o != 0 && (m_stb_i & grant_o) != 0) sc++;
        if ((m_ack_o | m_err_o | m_rty_o) != 0) begin
          if (tq.size() == 0)
            chk("unexpected_term", {m_rty_o, m_err_o, m_ack_o}, 0);
          else begin
            e  = tq.pop_front();
            oh = 4'b1 << e.k;
            chk("m_ack", m_ack_o, e.resp[0] ? oh : 4'b0);
            chk("m_err", m_err_o, e.resp[1] ? oh : 4'b0);
            chk("m_rty", m_rty_o, e.resp[2] ? oh : 4'b0);
            chk("s_stb_at_term", s_stb_o, !e.to);
            chk("stb_cycles", sc, e.to ? TO + 1 : e.wt + 1);
            chk("s_adr", s_adr_o, e.adr);
            chk("s_we", s_we_o, e.we);
            chk("s_sel", s_sel_o, e.sel);
            if (e.we) chk("s_dat", s_dat_o, e.dat);
            else chk("m_dat", m_dat_o, {e.adr, ~e.adr});
          end
          sc = 0;
        end
        prev_g = grant_o;
      end
    end
  end

  task automatic fill(input int k, input int nb);
    p_nb[k] = nb;
    for (int b = 0; b < 3; b++) begin
      int r;
      r = $urandom % 16;
      p_adr[k][b]  = {12'($urandom), 2'(k), 2'(b)};
      p_dat[k][b]  = $urandom;
      p_sel[k][b]  = 4'($urandom);
      p_we[k][b]   = 1'($urandom);
      p_wait[k][b] = $urandom % 4;
      p_to[k][b]   = (r >= 14);
      p_resp[k][b] = r < 10 ? 3'b001 : r == 10 ? 3'b010 :
                     r == 11 ? 3'b100 : r == 12 ? 3'b011 : 3'b110;
    end
  endtask

  task automatic setb(input int k, input int b, input int wt,
                      input logic [2:0] resp, input logic to);
    p_wait[k][b] = wt;
    p_resp[k][b] = resp;
    p_to[k][b]   = to;
  endtask

  task automatic plain(input int k, input int nb);
    fill(k, nb);
    for (int b = 0; b < 3; b++) setb(k, b, 0, 3'b001, 1'b0);
  endtask

  function automatic bit all_done();
    return mst[0].fin == go_ep && mst[1].fin == go_ep &&
           mst[2].fin == go_ep && mst[3].fin == go_ep;
  endfunction

  // All of r request together and hold until served: rotated order
  task automatic launch(input logic [3:0] r);
    int   order[$];
    int   k, n;
    exp_t e;
    for (int i = 1; i <= 4; i++) begin
      k = (ptr + i) % 4;
      if (r[k]) order.push_back(k);
    end
    foreach (order[j]) begin
      k = order[j];
      gq.push_back(k);
      for (int b = 0; b < p_nb[k]; b++) begin
        e.k = k; e.to = p_to[k][b]; e.wt = p_wait[k][b];
        e.resp = p_to[k][b] ? 3'b010 : p_resp[k][b];
        e.adr = p_adr[k][b]; e.we = p_we[k][b];
        e.dat = p_dat[k][b]; e.sel = p_sel[k][b];
        tq.push_back(e);
      end
    end
    ptr = order[order.size() - 1];
    req = r;
    go_ep++;
    n = 0;
    while (!all_done() && n < 2000) begin
      @(posedge clk); n++;
    end
    if (!all_done()) begin
      chk("episode_timeout", n, 0);
      abort = 1;
      repeat (3) @(posedge clk);
      abort = 0;
      gq.delete(); tq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1;
    for (int k = 0; k < 4; k++) plain(k, 1);
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    ptr = 3;
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_terms", {m_rty_o, m_err_o, m_ack_o}, 0);

    launch(4'b0101);
    for (int k = 0; k < 4; k++) plain(k, 1);
    launch(4'b1111);
    launch(4'b1111);

    plain(1, 1);
    launch(4'b0010);
    plain(2, 3);
    plain(1, 1);
    setb(2, 1, 2, 3'b001, 1'b0);
    launch(4'b0110);

    plain(1, 1);
    setb(1, 0, 0, 3'b001, 1'b1);
    launch(4'b0010);

    plain(3, 2);
    setb(3, 0, 1, 3'b010, 1'b0);
    setb(3, 1, 1, 3'b100, 1'b0);
    launch(4'b1000);

    // reset while master 0 owns the bus mid-strobe
    plain(0, 1);
    setb(0, 0, 3, 3'b001, 1'b0);
    gq.push_back(0);
    req = 4'b0001;
    go_ep++;
    @(posedge clk);
    @(posedge clk);
    #1 rst_i = 1; abort = 1;
    @(posedge clk);
    #1 rst_i = 0; abort = 0;
    #1;
    chk("midrst_grant", grant_o, 0);
    chk("midrst_s_cyc", s_cyc_o, 0);
    ptr = 3;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) plain(k, 1);
    launch(4'b1011);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) fill(k, $urandom_range(1, 3));
      launch(4'($urandom_range(1, 15)));
    end

    repeat (4) @(posedge clk);
    chk("grants_left", gq.size(), 0);
    chk("terms_left", tq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
